// File: rtl/button_event.sv
// Push-button event decoder on the 1 ms tick: turns a debounced level into press, release,
// click, long-press and auto-repeat pulses plus a held level. All outputs are registered.
module button_event #(
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic clk_1ms,
  input  logic rst_n,
  input  logic pbreg,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StLong    = 2'd2
  } state_e;

  localparam logic [15:0] HoldLast   = 16'(LONG_MS - 1);
  localparam logic [15:0] RepeatLast = 16'(REPEAT_MS - 1);

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] rpt_q, rpt_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        click_q, click_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pbreg) begin
          state_d = StPressed;
          hold_d  = 16'd1;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        // Release is tested first so it wins over an expiring hold count.
        if (!pbreg) begin
          state_d   = StIdle;
          hold_d    = 16'd0;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (hold_q >= HoldLast) begin
          state_d = StLong;
          rpt_d   = 16'd0;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      StLong: begin
        if (!pbreg) begin
          state_d   = StIdle;
          hold_d    = 16'd0;
          rpt_d     = 16'd0;
          release_d = 1'b1;
        end else if (!repeat_en) begin
          rpt_d = 16'd0;
        end else if (rpt_q >= RepeatLast) begin
          rpt_d    = 16'd0;
          repeat_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = 16'd0;
        rpt_d   = 16'd0;
      end
    endcase

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= 16'd0;
      rpt_q     <= 16'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios with literal expectations plus randomized
// press/hold/release traffic checked every edge against an age-based press model.
module tb_button_event;

  localparam int unsigned L = 5;
  localparam int unsigned R = 3;

  logic clk_1ms = 1'b0;
  logic rst_n;
  logic pbreg;
  logic repeat_en;
  logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

  button_event #(
    .LONG_MS  (L),
    .REPEAT_MS(R)
  ) dut (
    .clk_1ms      (clk_1ms),
    .rst_n        (rst_n),
    .pbreg        (pbreg),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk_1ms = ~clk_1ms;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: a press is tracked by its age in edges since the press edge.
  bit m_active;
  int m_age;
  int m_run;
  logic [5:0] exp_v;  // {press, release, click, long, repeat, held}

  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_run    = 0;
    exp_v    = 6'b0;
  endtask

  task automatic model_step(input logic pb, input logic en);
    logic p, r, c, lg, rp;
    {p, r, c, lg, rp} = 5'b0;
    if (!m_active) begin
      if (pb) begin
        m_active = 1'b1;
        m_age    = 0;
        p        = 1'b1;
      end
    end else if (!pb) begin
      m_active = 1'b0;
      r        = 1'b1;
      c        = (m_age < int'(L) - 1);
    end else begin
      if (m_age < int'(L)) m_age++;
      if (m_age == int'(L) - 1) begin
        lg    = 1'b1;
        m_run = 0;
      end else if (m_age >= int'(L)) begin
        if (en) begin
          m_run++;
          if (m_run == int'(R)) begin
            rp    = 1'b1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    exp_v = {p, r, c, lg, rp, m_active};
  endtask

  always @(negedge rst_n) model_reset();

  // Per-edge comparison against the model, plus the one-hot / click / held invariants.
  always begin
    @(posedge clk_1ms);
    if (rst_n) model_step(pbreg, repeat_en);
    else exp_v = 6'b0;
    #1;
    if (cmp_en) begin
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got=%b want=%b", $time, outs(), exp_v);
      end
      checks++;
      if (!$onehot0({press_pulse, release_pulse, long_pulse, repeat_pulse}) ||
          (click_pulse && !release_pulse) || (held !== m_active)) begin
        errors++;
        $display("FAIL invariant t=%0t got=%b want held=%b onehot0", $time, outs(), m_active);
      end
    end
  end

  task automatic chk(input string name, input int edge_n, input logic [5:0] got,
                     input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edge_n, got, want);
    end
  endtask

  task automatic step(input logic pb, input logic en, output logic [5:0] obs);
    @(negedge clk_1ms);
    pbreg     = pb;
    repeat_en = en;
    @(posedge clk_1ms);
    #1;
    obs = outs();
  endtask

  task automatic go_idle();
    logic [5:0] o;
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    chk("idle", 0, o, 6'b000000);
  endtask

  // Drops reset between edges, checks immediate clear, releases on the next falling edge.
  task automatic async_reset(input bit check);
    @(posedge clk_1ms);
    #3;
    rst_n = 1'b0;
    #1;
    if (check) chk("async_reset", 0, outs(), 6'b000000);
    @(negedge clk_1ms);
    rst_n = 1'b1;
  endtask

  logic [5:0] exp32[4];
  logic [5:0] exp33[13];
  logic [5:0] exp34[5];
  logic [5:0] exp35[13];

  initial begin
    logic [5:0] o;
    exp32 = '{6'b100001, 6'b000001, 6'b000001, 6'b011000};
    exp33 = '{6'b100001, 6'b000001, 6'b000001, 6'b000001, 6'b000101, 6'b000001, 6'b000001,
              6'b000011, 6'b000001, 6'b000001, 6'b000011, 6'b000001, 6'b010000};
    exp34 = '{6'b100001, 6'b000001, 6'b000001, 6'b000001, 6'b011000};
    exp35 = '{6'b100001, 6'b000001, 6'b000001, 6'b000001, 6'b000101, 6'b000001, 6'b000001,
              6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000011, 6'b010000};

    model_reset();
    rst_n     = 1'b0;
    pbreg     = 1'b0;
    repeat_en = 1'b0;
    #2;
    chk("reset_state", 0, outs(), 6'b000000);
    repeat (2) @(negedge clk_1ms);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    go_idle();
    for (int e = 1; e <= 4; e++) begin
      step(e <= 3, 1'b1, o);
      chk("short_click", e, o, exp32[e-1]);
    end

    go_idle();
    for (int e = 1; e <= 13; e++) begin
      step(e <= 12, 1'b1, o);
      chk("long_repeat", e, o, exp33[e-1]);
    end

    go_idle();
    for (int e = 1; e <= 5; e++) begin
      step(e <= 4, 1'b1, o);
      chk("release_wins", e, o, exp34[e-1]);
    end

    go_idle();
    for (int e = 1; e <= 13; e++) begin
      step(e <= 12, !(e >= 6 && e <= 9), o);
      chk("repeat_gate", e, o, exp35[e-1]);
    end

    // Reset while in long hold with the button still down.
    go_idle();
    for (int e = 1; e <= 7; e++) step(1'b1, 1'b1, o);
    chk("pre_reset_long", 7, o, 6'b000001);
    async_reset(1'b1);
    @(posedge clk_1ms);
    #1;
    chk("press_after_reset", 1, outs(), 6'b100001);
    step(1'b1, 1'b1, o);
    chk("held_after_reset", 2, o, 6'b000001);

    // Randomized traffic: alternating level runs, sporadic enable flips and resets.
    begin
      logic lvl, en;
      int   run;
      lvl = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if (run <= 0) begin
          lvl = ~lvl;
          run = $urandom_range(14, 1);
        end
        run--;
        if ($urandom_range(7, 0) == 0) en = ~en;
        if ($urandom_range(399, 0) == 0) async_reset(1'b0);
        else step(lvl, en, o);
      end
    end

    go_idle();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
